// File: rtl/ldpc_edge_map_rom.sv
// Edge-address generator for the layered 802.16e rate-1/2 LDPC decoder: walks a node
// counter and emits, per edge lane, the neighbour node index and the edge's branch slot there.
module ldpc_edge_map_rom #(
    parameter int unsigned EXPANSION_FACTOR = 96,
    parameter              DIRECTION        = "C2R",
    parameter int unsigned IDX_W            = (DIRECTION == "R2C") ? $clog2(24 * EXPANSION_FACTOR)
                                                                   : $clog2(12 * EXPANSION_FACTOR)
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_valid,
    output logic [IDX_W-1:0] o_index_for_a0,
    output logic [IDX_W-1:0] o_index_for_a1,
    output logic [IDX_W-1:0] o_index_for_a2,
    output logic [IDX_W-1:0] o_index_for_a3,
    output logic [IDX_W-1:0] o_index_for_a4,
    output logic [IDX_W-1:0] o_index_for_a5,
    output logic [IDX_W-1:0] o_index_for_a6,
    output logic [2:0]       o_branch_for_a0,
    output logic [2:0]       o_branch_for_a1,
    output logic [2:0]       o_branch_for_a2,
    output logic [2:0]       o_branch_for_a3,
    output logic [2:0]       o_branch_for_a4,
    output logic [2:0]       o_branch_for_a5,
    output logic [2:0]       o_branch_for_a6
);

    localparam int unsigned Z     = EXPANSION_FACTOR;
    localparam bit          C2R   = (DIRECTION != "R2C");
    localparam int unsigned NB    = C2R ? 24 : 12;
    localparam int unsigned WALK  = C2R ? 12 : 24;
    localparam int unsigned B_W   = $clog2(NB);
    localparam int unsigned OFF_W = $clog2(Z);
    localparam int unsigned LANES = 7;
    localparam logic [OFF_W:0] ZP = (OFF_W + 1)'(Z);

    // Rate-1/2 prototype, shifts for Z=96; -1 marks a zero block.
    localparam int BASE [12][24] = '{
        '{-1, 94, 73, -1, -1, -1, -1, -1, 55, 83, -1, -1,  7,  0, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1},
        '{-1, 27, -1, -1, -1, 22, 79,  9, -1, -1, -1, 12, -1,  0,  0, -1, -1, -1, -1, -1, -1, -1, -1, -1},
        '{-1, -1, -1, 24, 22, 81, -1, 33, -1, -1, -1,  0, -1, -1,  0,  0, -1, -1, -1, -1, -1, -1, -1, -1},
        '{61, -1, 47, -1, -1, -1, -1, -1, 65, 25, -1, -1, -1, -1, -1,  0,  0, -1, -1, -1, -1, -1, -1, -1},
        '{-1, -1, 39, -1, -1, -1, 84, -1, -1, 41, 72, -1, -1, -1, -1, -1,  0,  0, -1, -1, -1, -1, -1, -1},
        '{-1, -1, -1, -1, 46, 40, -1, 82, -1, -1, -1, 79,  0, -1, -1, -1, -1,  0,  0, -1, -1, -1, -1, -1},
        '{-1, -1, 95, 53, -1, -1, -1, -1, -1, 14, 18, -1, -1, -1, -1, -1, -1, -1,  0,  0, -1, -1, -1, -1},
        '{-1, 11, 73, -1, -1, -1,  2, -1, -1, 47, -1, -1, -1, -1, -1, -1, -1, -1, -1,  0,  0, -1, -1, -1},
        '{12, -1, -1, -1, 83, 24, -1, 43, -1, -1, -1, 51, -1, -1, -1, -1, -1, -1, -1, -1,  0,  0, -1, -1},
        '{-1, -1, -1, -1, -1, 94, -1, 59, -1, -1, 70, 72, -1, -1, -1, -1, -1, -1, -1, -1, -1,  0,  0, -1},
        '{-1, -1,  7, 65, -1, -1, -1, -1, 39, 49, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1,  0,  0},
        '{43, -1, -1, -1, -1, 66, -1, 41, -1, -1, -1, 26,  7, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1,  0}
    };

    // Shift between base node bn on the walked side and base node j on the other side.
    function automatic int edge_shift(input int bn, input int j);
        return C2R ? BASE[j][bn] : BASE[bn][j];
    endfunction

    function automatic int lane_nbr(input int bn, input int k);
        int cnt;
        int res;
        cnt = 0;
        res = -1;
        for (int j = 0; j < int'(WALK); j++) begin
            if (edge_shift(bn, j) >= 0) begin
                if (cnt == k) res = j;
                cnt++;
            end
        end
        return res;
    endfunction

    // Other lifting sizes use the floor(p*Z/96) scaling of the prototype shifts.
    function automatic int lane_shift(input int bn, input int k);
        int nbr;
        nbr = lane_nbr(bn, k);
        if (nbr < 0) return 0;
        return (edge_shift(bn, nbr) * int'(Z)) / 96;
    endfunction

    function automatic int lane_branch(input int bn, input int k);
        int nbr;
        int cnt;
        nbr = lane_nbr(bn, k);
        cnt = 0;
        if (nbr < 0) return 7;
        for (int j = 0; j < bn; j++) begin
            if (edge_shift(j, nbr) >= 0) cnt++;
        end
        return cnt;
    endfunction

    logic             tab_used   [NB][LANES];
    logic [IDX_W-1:0] tab_off    [NB][LANES];
    logic [OFF_W-1:0] tab_shift  [NB][LANES];
    logic [2:0]       tab_branch [NB][LANES];

    // Per-base-node neighbour tables, folded to constants at elaboration.
    for (genvar gb = 0; gb < int'(NB); gb++) begin : g_node
        for (genvar gk = 0; gk < int'(LANES); gk++) begin : g_lane
            localparam int NBR    = lane_nbr(gb, gk);
            localparam int SHIFT  = lane_shift(gb, gk);
            localparam int BRANCH = lane_branch(gb, gk);
            localparam int OFF    = (NBR >= 0) ? NBR * int'(Z) : 0;
            assign tab_used[gb][gk]   = (NBR >= 0);
            assign tab_off[gb][gk]    = IDX_W'(OFF);
            assign tab_shift[gb][gk]  = OFF_W'(SHIFT);
            assign tab_branch[gb][gk] = 3'(BRANCH);
        end
    end

    logic [OFF_W-1:0] z_q;
    logic [B_W-1:0]   b_q;
    logic [IDX_W-1:0] idx_q [LANES];
    logic [2:0]       br_q  [LANES];
    logic [OFF_W:0]   mod_c [LANES];
    logic [IDX_W-1:0] idx_c [LANES];
    logic [2:0]       br_c  [LANES];

    // Per-lane mod-Z offset with a single conditional add/subtract of Z.
    always_comb begin
        for (int k = 0; k < int'(LANES); k++) begin
            mod_c[k] = '0;
            idx_c[k] = '0;
            br_c[k]  = 3'd7;
            if (tab_used[b_q][k]) begin
                if (C2R) begin
                    if ({1'b0, z_q} >= {1'b0, tab_shift[b_q][k]})
                        mod_c[k] = {1'b0, z_q} - {1'b0, tab_shift[b_q][k]};
                    else
                        mod_c[k] = {1'b0, z_q} + ZP - {1'b0, tab_shift[b_q][k]};
                end else begin
                    mod_c[k] = {1'b0, z_q} + {1'b0, tab_shift[b_q][k]};
                    if (mod_c[k] >= ZP) mod_c[k] = mod_c[k] - ZP;
                end
                idx_c[k] = tab_off[b_q][k] + IDX_W'(mod_c[k]);
                br_c[k]  = tab_branch[b_q][k];
            end
        end
    end

    // Node counter kept as (base, offset) so no division is needed per cycle.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            z_q <= '0;
            b_q <= '0;
            for (int k = 0; k < int'(LANES); k++) begin
                idx_q[k] <= '0;
                br_q[k]  <= '0;
            end
        end else if (i_valid) begin
            for (int k = 0; k < int'(LANES); k++) begin
                idx_q[k] <= idx_c[k];
                br_q[k]  <= br_c[k];
            end
            if (z_q == OFF_W'(Z - 1)) begin
                z_q <= '0;
                b_q <= (b_q == B_W'(NB - 1)) ? '0 : b_q + B_W'(1);
            end else begin
                z_q <= z_q + OFF_W'(1);
            end
        end
    end

    assign o_index_for_a0  = idx_q[0];
    assign o_index_for_a1  = idx_q[1];
    assign o_index_for_a2  = idx_q[2];
    assign o_index_for_a3  = idx_q[3];
    assign o_index_for_a4  = idx_q[4];
    assign o_index_for_a5  = idx_q[5];
    assign o_index_for_a6  = idx_q[6];
    assign o_branch_for_a0 = br_q[0];
    assign o_branch_for_a1 = br_q[1];
    assign o_branch_for_a2 = br_q[2];
    assign o_branch_for_a3 = br_q[3];
    assign o_branch_for_a4 = br_q[4];
    assign o_branch_for_a5 = br_q[5];
    assign o_branch_for_a6 = br_q[6];

endmodule

// File: tb/tb_ldpc_edge_map_rom.sv
// Bench for ldpc_edge_map_rom: C2R and R2C instances driven together and checked
// every cycle against a node-level model of the base-matrix edge mapping.
module tb_ldpc_edge_map_rom;

    localparam int Z  = 96;
    localparam int NC = 24 * Z;
    localparam int NR = 12 * Z;

    localparam int BASE [12][24] = '{
        '{-1, 94, 73, -1, -1, -1, -1, -1, 55, 83, -1, -1,  7,  0, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1},
        '{-1, 27, -1, -1, -1, 22, 79,  9, -1, -1, -1, 12, -1,  0,  0, -1, -1, -1, -1, -1, -1, -1, -1, -1},
        '{-1, -1, -1, 24, 22, 81, -1, 33, -1, -1, -1,  0, -1, -1,  0,  0, -1, -1, -1, -1, -1, -1, -1, -1},
        '{61, -1, 47, -1, -1, -1, -1, -1, 65, 25, -1, -1, -1, -1, -1,  0,  0, -1, -1, -1, -1, -1, -1, -1},
        '{-1, -1, 39, -1, -1, -1, 84, -1, -1, 41, 72, -1, -1, -1, -1, -1,  0,  0, -1, -1, -1, -1, -1, -1},
        '{-1, -1, -1, -1, 46, 40, -1, 82, -1, -1, -1, 79,  0, -1, -1, -1, -1,  0,  0, -1, -1, -1, -1, -1},
        '{-1, -1, 95, 53, -1, -1, -1, -1, -1, 14, 18, -1, -1, -1, -1, -1, -1, -1,  0,  0, -1, -1, -1, -1},
        '{-1, 11, 73, -1, -1, -1,  2, -1, -1, 47, -1, -1, -1, -1, -1, -1, -1, -1, -1,  0,  0, -1, -1, -1},
        '{12, -1, -1, -1, 83, 24, -1, 43, -1, -1, -1, 51, -1, -1, -1, -1, -1, -1, -1, -1,  0,  0, -1, -1},
        '{-1, -1, -1, -1, -1, 94, -1, 59, -1, -1, 70, 72, -1, -1, -1, -1, -1, -1, -1, -1, -1,  0,  0, -1},
        '{-1, -1,  7, 65, -1, -1, -1, -1, 39, 49, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1,  0,  0},
        '{43, -1, -1, -1, -1, 66, -1, 41, -1, -1, -1, 26,  7, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1,  0}
    };

    logic clk = 1'b0;
    logic rst;
    logic vld;
    logic [10:0] c_idx [7];
    logic [2:0]  c_br  [7];
    logic [11:0] r_idx [7];
    logic [2:0]  r_br  [7];

    always #5 clk = ~clk;

    ldpc_edge_map_rom #(.EXPANSION_FACTOR(96), .DIRECTION("C2R")) u_c2r (
        .i_clock(clk), .i_reset(rst), .i_valid(vld),
        .o_index_for_a0(c_idx[0]), .o_index_for_a1(c_idx[1]), .o_index_for_a2(c_idx[2]),
        .o_index_for_a3(c_idx[3]), .o_index_for_a4(c_idx[4]), .o_index_for_a5(c_idx[5]),
        .o_index_for_a6(c_idx[6]),
        .o_branch_for_a0(c_br[0]), .o_branch_for_a1(c_br[1]), .o_branch_for_a2(c_br[2]),
        .o_branch_for_a3(c_br[3]), .o_branch_for_a4(c_br[4]), .o_branch_for_a5(c_br[5]),
        .o_branch_for_a6(c_br[6])
    );

    ldpc_edge_map_rom #(.EXPANSION_FACTOR(96), .DIRECTION("R2C")) u_r2c (
        .i_clock(clk), .i_reset(rst), .i_valid(vld),
        .o_index_for_a0(r_idx[0]), .o_index_for_a1(r_idx[1]), .o_index_for_a2(r_idx[2]),
        .o_index_for_a3(r_idx[3]), .o_index_for_a4(r_idx[4]), .o_index_for_a5(r_idx[5]),
        .o_index_for_a6(r_idx[6]),
        .o_branch_for_a0(r_br[0]), .o_branch_for_a1(r_br[1]), .o_branch_for_a2(r_br[2]),
        .o_branch_for_a3(r_br[3]), .o_branch_for_a4(r_br[4]), .o_branch_for_a5(r_br[5]),
        .o_branch_for_a6(r_br[6])
    );

    int checks = 0;
    int errors = 0;
    bit checking = 1'b0;

    // Expected lane k of node n: neighbour index, or branch slot when want_br is set.
    function automatic int exp_lane(input bit c2r, input int n, input int k, input bit want_br);
        int b, z, cnt, p, pos;
        b = n / Z;
        z = n % Z;
        cnt = 0;
        for (int j = 0; j < (c2r ? 12 : 24); j++) begin
            p = c2r ? BASE[j][b] : BASE[b][j];
            if (p >= 0) begin
                if (cnt == k) begin
                    if (!want_br) return c2r ? j * Z + (z - p + Z) % Z : j * Z + (z + p) % Z;
                    pos = 0;
                    for (int m = 0; m < b; m++)
                        if ((c2r ? BASE[j][m] : BASE[m][j]) >= 0) pos++;
                    return pos;
                end
                cnt++;
            end
        end
        return want_br ? 7 : 0;
    endfunction

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Model: node counters and expected registered outputs.
    int n_c = 0, n_r = 0;
    int e_ci [7], e_cb [7], e_ri [7], e_rb [7];

    always @(posedge clk) begin
        if (rst) begin
            n_c <= 0;
            n_r <= 0;
            for (int k = 0; k < 7; k++) begin
                e_ci[k] <= 0; e_cb[k] <= 0; e_ri[k] <= 0; e_rb[k] <= 0;
            end
        end else if (vld) begin
            for (int k = 0; k < 7; k++) begin
                e_ci[k] <= exp_lane(1'b1, n_c, k, 1'b0);
                e_cb[k] <= exp_lane(1'b1, n_c, k, 1'b1);
                e_ri[k] <= exp_lane(1'b0, n_r, k, 1'b0);
                e_rb[k] <= exp_lane(1'b0, n_r, k, 1'b1);
            end
            n_c <= (n_c + 1) % NC;
            n_r <= (n_r + 1) % NR;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            for (int k = 0; k < 7; k++) begin
                checks++;
                if (int'(c_idx[k]) != e_ci[k] || int'(c_br[k]) != e_cb[k]) begin
                    errors++;
                    if (errors <= 20)
                        $display("FAIL c2r_lane%0d @%0t: got idx %0d br %0d, expected idx %0d br %0d",
                                 k, $time, c_idx[k], c_br[k], e_ci[k], e_cb[k]);
                end
                checks++;
                if (int'(r_idx[k]) != e_ri[k] || int'(r_br[k]) != e_rb[k]) begin
                    errors++;
                    if (errors <= 20)
                        $display("FAIL r2c_lane%0d @%0t: got idx %0d br %0d, expected idx %0d br %0d",
                                 k, $time, r_idx[k], r_br[k], e_ri[k], e_rb[k]);
                end
            end
        end
    end

    int c2r_i [NC][7];
    int c2r_b [NC][7];
    int r2c_i [NR][7];
    int r2c_b [NR][7];
    int cov   [NR][8];
    int row_last_i [7] = '{42, 545, 712, 1081, 1158, 2303, 0};
    int row_last_b [7] = '{2, 5, 5, 5, 2, 1, 7};
    int col0_i [3] = '{323, 852, 1109};

    initial begin
        int pass2_bad, cov_bad, cross_bad, edges, deg, b, c;
        bit did_reset;
        rst = 1'b1;
        vld = 1'b0;
        repeat (3) @(negedge clk);
        checking = 1'b1;
        rst = 1'b0;

        // Hand-computed anchors for the model itself.
        for (int k = 0; k < 3; k++) begin
            check_int("model_col0_idx", exp_lane(1'b1, 0, k, 1'b0), col0_i[k]);
            check_int("model_col0_br", exp_lane(1'b1, 0, k, 1'b1), 0);
        end
        check_int("model_row0_a0_idx", exp_lane(1'b0, 0, 0, 1'b0), 190);
        check_int("model_row0_a5_idx", exp_lane(1'b0, 0, 5, 1'b0), 1248);
        check_int("model_row1151_a5_idx", exp_lane(1'b0, 1151, 5, 1'b0), 2303);
        check_int("model_col2303_a0_br", exp_lane(1'b1, 2303, 0, 1'b1), 5);

        repeat (1000) @(negedge clk);
        check_int("idle_c2r_a0_idx", int'(c_idx[0]), 0);
        check_int("idle_c2r_a0_br", int'(c_br[0]), 0);
        check_int("idle_r2c_a6_br", int'(r_br[6]), 0);

        // Full C2R pass = two R2C passes.
        pass2_bad = 0;
        vld = 1'b1;
        for (int i = 0; i < NC; i++) begin
            @(negedge clk);
            for (int k = 0; k < 7; k++) begin
                c2r_i[i][k] = int'(c_idx[k]);
                c2r_b[i][k] = int'(c_br[k]);
                if (i < NR) begin
                    r2c_i[i][k] = int'(r_idx[k]);
                    r2c_b[i][k] = int'(r_br[k]);
                end else if (int'(r_idx[k]) != r2c_i[i - NR][k] || int'(r_br[k]) != r2c_b[i - NR][k]) begin
                    pass2_bad++;
                end
            end
        end
        vld = 1'b0;
        @(negedge clk);
        check_int("r2c_second_pass_diffs", pass2_bad, 0);

        check_int("col2303_a0_idx", int'(c_idx[0]), 1055);
        check_int("col2303_a0_br", int'(c_br[0]), 5);
        check_int("col2303_a1_idx", int'(c_idx[1]), 1151);
        check_int("col2303_a1_br", int'(c_br[1]), 5);
        for (int k = 2; k < 6; k++) begin
            check_int("col2303_unused_idx", int'(c_idx[k]), 0);
            check_int("col2303_unused_br", int'(c_br[k]), 7);
        end
        for (int k = 0; k < 7; k++) begin
            check_int("row1151_idx", int'(r_idx[k]), row_last_i[k]);
            check_int("row1151_br", int'(r_br[k]), row_last_b[k]);
        end

        // Every row r must appear once per branch slot 0..deg(r)-1 across the C2R pass.
        cov_bad = 0;
        for (int r = 0; r < NR; r++)
            for (int s = 0; s < 8; s++) cov[r][s] = 0;
        for (int cc = 0; cc < NC; cc++)
            for (int k = 0; k < 7; k++) begin
                b = c2r_b[cc][k];
                if (b != 7) begin
                    if (b > 6 || c2r_i[cc][k] >= NR) cov_bad++;
                    else cov[c2r_i[cc][k]][b]++;
                end
            end
        for (int r = 0; r < NR; r++) begin
            deg = 0;
            for (int j = 0; j < 24; j++) if (BASE[r / Z][j] >= 0) deg++;
            for (int s = 0; s < 7; s++)
                if (cov[r][s] != ((s < deg) ? 1 : 0)) cov_bad++;
        end
        check_int("c2r_row_coverage_bad", cov_bad, 0);

        // R2C edge (r, k) -> (c, b) must be mirrored by C2R column c lane b -> (r, k).
        cross_bad = 0;
        edges = 0;
        for (int r = 0; r < NR; r++)
            for (int k = 0; k < 7; k++) begin
                b = r2c_b[r][k];
                if (b != 7) begin
                    edges++;
                    c = r2c_i[r][k];
                    if (c >= NC || b > 6) cross_bad++;
                    else if (c2r_i[c][b] != r || c2r_b[c][b] != k) cross_bad++;
                end
            end
        check_int("cross_consistency_bad", cross_bad, 0);
        check_int("r2c_edge_count", edges, 76 * Z);

        // Counter wrapped: next valid is node 0 on both sides.
        vld = 1'b1;
        @(negedge clk);
        vld = 1'b0;
        for (int k = 0; k < 3; k++) check_int("wrap_col0_idx", int'(c_idx[k]), col0_i[k]);
        check_int("wrap_row0_a0_idx", int'(r_idx[0]), 190);

        // Toggled valid with a reset pulse at C2R node 500.
        did_reset = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            vld = (i % 2 == 0);
            @(negedge clk);
            if (!did_reset && n_c == 500) begin
                rst = 1'b1;
                vld = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                vld = 1'b0;
                @(negedge clk);
                check_int("reset_c2r_a0_idx", int'(c_idx[0]), 0);
                check_int("reset_r2c_a0_br", int'(r_br[0]), 0);
                vld = 1'b1;
                @(negedge clk);
                vld = 1'b0;
                check_int("post_reset_c2r_a0_idx", int'(c_idx[0]), 323);
                check_int("post_reset_r2c_a0_idx", int'(r_idx[0]), 190);
                did_reset = 1'b1;
            end
        end
        check_int("reset_pulse_reached", int'(did_reset), 1);

        vld = 1'b0;
        repeat (2) @(negedge clk);
        checking = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
